// File: rtl/cpu_pipe_pkg.sv
// Shared types and limits for the in-order pipeline hazard controller.
// Holds the FSM state encoding, instruction classes and parameter ranges.
package cpu_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        FLUSH    = 3'd2,
        BR_WAIT  = 3'd3,
        MEM_WAIT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_JUMP   = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4
    } iclass_e;

    localparam int HAZ_DEPTH_MIN  = 1;
    localparam int HAZ_DEPTH_MAX  = 4;
    localparam int PENALTY_MIN    = 1;
    localparam int PENALTY_MAX    = 7;
    localparam int BR_RES_LAT_MAX = 3;
    localparam int CNT_W          = 3;

    // Class flags are nominally one-hot; if several are set, jump wins, then branch, load, store.
    function automatic iclass_e decode_class(input logic is_jump, input logic is_branch,
                                             input logic is_load, input logic is_store);
        if (is_jump)   return CLS_JUMP;
        if (is_branch) return CLS_BRANCH;
        if (is_load)   return CLS_LOAD;
        if (is_store)  return CLS_STORE;
        return CLS_ALU;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Read-after-write comparator: flags a decode-stage source register that a
// downstream stage is about to write. Register 0 never creates a dependency.
module hazard_cmp
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int HAZ_DEPTH = 2
) (
    input  logic                       dec_valid,
    input  logic [REG_W-1:0]           dec_rs1,
    input  logic [REG_W-1:0]           dec_rs2,
    input  logic                       dec_use_rs1,
    input  logic                       dec_use_rs2,
    input  logic [HAZ_DEPTH*REG_W-1:0] stg_rd,
    input  logic [HAZ_DEPTH-1:0]       stg_rd_we,
    output logic                       dep
);

    if (HAZ_DEPTH < HAZ_DEPTH_MIN || HAZ_DEPTH > HAZ_DEPTH_MAX) begin : g_bad_depth
        $error("hazard_cmp: HAZ_DEPTH must be within 1..4");
    end

    logic any_match;

    always_comb begin
        any_match = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (stg_rd_we[i] && (stg_rd[i*REG_W +: REG_W] != '0) &&
                ((dec_use_rs1 && (stg_rd[i*REG_W +: REG_W] == dec_rs1)) ||
                 (dec_use_rs2 && (stg_rd[i*REG_W +: REG_W] == dec_rs2)))) begin
                any_match = 1'b1;
            end
        end
    end

    assign dep = dec_valid & any_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller beside decode: RAW stalls, jump/branch flushes,
// load/store memory waits, one posted store and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int HAZ_DEPTH   = 2,
    parameter int JMP_PENALTY = 2,
    parameter int BR_RES_LAT  = 1,
    parameter int BR_PENALTY  = 2,
    parameter int MEM_MIN     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    input  logic [REG_W-1:0]           dec_rs1,
    input  logic [REG_W-1:0]           dec_rs2,
    input  logic                       dec_use_rs1,
    input  logic                       dec_use_rs2,
    input  logic                       dec_is_jump,
    input  logic                       dec_is_branch,
    input  logic                       dec_is_load,
    input  logic                       dec_is_store,
    input  logic [HAZ_DEPTH*REG_W-1:0] stg_rd,
    input  logic [HAZ_DEPTH-1:0]       stg_rd_we,
    input  logic                       br_taken,
    input  logic                       mem_busy,
    output logic                       en_fetch,
    output logic                       en_decode,
    output logic                       en_exec,
    output logic                       en_wb,
    output logic                       en_regs,
    output logic                       en_addr,
    output logic                       bubble,
    output logic                       flush,
    output logic                       wr_pending,
    output logic [2:0]                 state,
    output logic [15:0]                stall_cycles
);

    if (JMP_PENALTY < PENALTY_MIN || JMP_PENALTY > PENALTY_MAX ||
        BR_PENALTY  < PENALTY_MIN || BR_PENALTY  > PENALTY_MAX ||
        MEM_MIN     < PENALTY_MIN || MEM_MIN     > PENALTY_MAX ||
        BR_RES_LAT  < PENALTY_MIN || BR_RES_LAT  > BR_RES_LAT_MAX) begin : g_bad_penalty
        $error("pipe_hazard_ctrl: penalty/latency parameter out of range");
    end

    logic               dep;
    iclass_e            cls;
    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_pending_q, wr_pending_d;
    logic [15:0]        stall_q, stall_d;
    logic               store_acc, mem_leave;

    hazard_cmp #(.REG_W(REG_W), .HAZ_DEPTH(HAZ_DEPTH)) u_hazard_cmp (
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .stg_rd      (stg_rd),
        .stg_rd_we   (stg_rd_we),
        .dep         (dep)
    );

    assign cls = dec_valid ? decode_class(dec_is_jump, dec_is_branch, dec_is_load, dec_is_store)
                           : CLS_ALU;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (!dep) begin
                        case (cls)
                            CLS_JUMP:   begin state_q <= FLUSH;    cnt_q <= CNT_W'(JMP_PENALTY); end
                            CLS_BRANCH: begin state_q <= BR_WAIT;  cnt_q <= CNT_W'(BR_RES_LAT);  end
                            CLS_LOAD:   begin state_q <= MEM_WAIT; cnt_q <= CNT_W'(MEM_MIN);     end
                            CLS_STORE: begin
                                if (wr_pending_q) begin
                                    state_q <= MEM_WAIT;
                                    cnt_q   <= CNT_W'(MEM_MIN);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FLUSH: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_q <= RUN;
                end
                BR_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    // br_taken is only meaningful on the last resolution cycle
                    if (cnt_q <= CNT_W'(1)) begin
                        if (br_taken) begin
                            state_q <= FLUSH;
                            cnt_q   <= CNT_W'(BR_PENALTY);
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    if (mem_leave) state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        en_fetch  = 1'b0;
        en_decode = 1'b0;
        en_exec   = 1'b0;
        en_wb     = 1'b0;
        en_regs   = 1'b0;
        en_addr   = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            RUN: begin
                en_exec = 1'b1;
                en_wb   = 1'b1;
                en_regs = 1'b1;
                en_addr = 1'b1;
                if (dep) begin
                    bubble = 1'b1;
                end else begin
                    en_fetch  = 1'b1;
                    en_decode = 1'b1;
                end
            end
            FLUSH: begin
                flush    = 1'b1;
                en_fetch = 1'b1;
                en_exec  = 1'b1;
                en_wb    = 1'b1;
            end
            BR_WAIT: begin
                en_exec = 1'b1;
                en_wb   = 1'b1;
            end
            MEM_WAIT: begin
                en_wb   = 1'b1;
                en_regs = 1'b1;
            end
            default: ;
        endcase
    end

    assign store_acc = (state_q == RUN) && !dep && (cls == CLS_STORE) && !wr_pending_q;
    assign mem_leave = (state_q == MEM_WAIT) && (cnt_q <= CNT_W'(1)) && !mem_busy;

    always_comb begin
        wr_pending_d = wr_pending_q;
        if (store_acc)                  wr_pending_d = 1'b1;
        else if (!mem_busy || mem_leave) wr_pending_d = 1'b0;

        stall_d = stall_q;
        if ((!en_fetch || flush) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_pending_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            wr_pending_q <= wr_pending_d;
            stall_q      <= stall_d;
        end
    end

    assign wr_pending   = wr_pending_q;
    assign stall_cycles = stall_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// stimulus compared every cycle against a schedule-queue reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W       = 5;
    localparam int HAZ_DEPTH   = 2;
    localparam int JMP_PENALTY = 2;
    localparam int BR_RES_LAT  = 1;
    localparam int BR_PENALTY  = 2;
    localparam int MEM_MIN     = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_BR    = 3;
    localparam int M_MEM   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       dec_valid;
    logic [REG_W-1:0]           dec_rs1, dec_rs2;
    logic                       dec_use_rs1, dec_use_rs2;
    logic                       dec_is_jump, dec_is_branch, dec_is_load, dec_is_store;
    logic [HAZ_DEPTH*REG_W-1:0] stg_rd;
    logic [HAZ_DEPTH-1:0]       stg_rd_we;
    logic                       br_taken, mem_busy;
    logic                       en_fetch, en_decode, en_exec, en_wb, en_regs, en_addr;
    logic                       bubble, flush, wr_pending;
    logic [2:0]                 state;
    logic [15:0]                stall_cycles;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .HAZ_DEPTH(HAZ_DEPTH), .JMP_PENALTY(JMP_PENALTY),
        .BR_RES_LAT(BR_RES_LAT), .BR_PENALTY(BR_PENALTY), .MEM_MIN(MEM_MIN)
    ) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_is_jump(dec_is_jump), .dec_is_branch(dec_is_branch),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
        .stg_rd(stg_rd), .stg_rd_we(stg_rd_we),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .en_fetch(en_fetch), .en_decode(en_decode), .en_exec(en_exec), .en_wb(en_wb),
        .en_regs(en_regs), .en_addr(en_addr), .bubble(bubble), .flush(flush),
        .wr_pending(wr_pending), .state(state), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of upcoming non-RUN cycles; empty queue means RUN.
    int sched[$];
    bit m_idle;
    bit m_wp;
    int m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_dep();
        logic [REG_W-1:0] rd;
        if (!dec_valid) return 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            rd = stg_rd[i*REG_W +: REG_W];
            if (stg_rd_we[i] && rd != 0 &&
                ((dec_use_rs1 && rd == dec_rs1) || (dec_use_rs2 && rd == dec_rs2)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int mode();
        if (m_idle) return M_IDLE;
        if (sched.size() == 0) return M_RUN;
        return sched[0];
    endfunction

    // {fetch, decode, exec, wb, regs, addr, bubble, flush}
    function automatic logic [7:0] exp_vec(input int m, input bit d);
        case (m)
            M_RUN:   return d ? 8'b0011_1110 : 8'b1111_1100;
            M_FLUSH: return 8'b1011_0001;
            M_BR:    return 8'b0011_0000;
            M_MEM:   return 8'b0001_1000;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        sched.delete();
        m_idle  = 1'b1;
        m_wp    = 1'b0;
        m_stall = 0;
    endtask

    task automatic model_step();
        int m;
        bit d, st_acc, leave;
        logic [7:0] v;
        m = mode();
        d = model_dep();
        v = exp_vec(m, d);
        st_acc = 1'b0;
        leave  = 1'b0;
        if (!v[7] || v[0]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        case (m)
            M_IDLE: m_idle = 1'b0;
            M_RUN: begin
                if (!d && dec_valid) begin
                    if (dec_is_jump)        repeat (JMP_PENALTY) sched.push_back(M_FLUSH);
                    else if (dec_is_branch) repeat (BR_RES_LAT)  sched.push_back(M_BR);
                    else if (dec_is_load)   repeat (MEM_MIN)     sched.push_back(M_MEM);
                    else if (dec_is_store) begin
                        if (!m_wp) st_acc = 1'b1;
                        else repeat (MEM_MIN) sched.push_back(M_MEM);
                    end
                end
            end
            M_FLUSH: void'(sched.pop_front());
            M_BR: begin
                void'(sched.pop_front());
                if (sched.size() == 0 && br_taken) repeat (BR_PENALTY) sched.push_back(M_FLUSH);
            end
            M_MEM: begin
                if (sched.size() > 1) void'(sched.pop_front());
                else if (!mem_busy) begin
                    void'(sched.pop_front());
                    leave = 1'b1;
                end
            end
            default: ;
        endcase
        if (st_acc)                 m_wp = 1'b1;
        else if (!mem_busy || leave) m_wp = 1'b0;
    endtask

    task automatic settle();
        #1;
        chk("state", 32'(state), 32'(mode()));
        chk("enables", 32'({en_fetch, en_decode, en_exec, en_wb, en_regs, en_addr, bubble, flush}),
            32'(exp_vec(mode(), model_dep())));
        chk("wr_pending", 32'(wr_pending), 32'(m_wp));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic clear_decode();
        dec_valid     = 1'b0;
        dec_rs1       = '0;
        dec_rs2       = '0;
        dec_use_rs1   = 1'b0;
        dec_use_rs2   = 1'b0;
        dec_is_jump   = 1'b0;
        dec_is_branch = 1'b0;
        dec_is_load   = 1'b0;
        dec_is_store  = 1'b0;
        stg_rd        = '0;
        stg_rd_we     = '0;
    endtask

    task automatic rand_inputs();
        int c;
        clear_decode();
        dec_valid   = ($urandom_range(0, 3) != 0);
        dec_rs1     = REG_W'($urandom_range(0, 7));
        dec_rs2     = REG_W'($urandom_range(0, 7));
        dec_use_rs1 = 1'($urandom_range(0, 1));
        dec_use_rs2 = 1'($urandom_range(0, 1));
        for (int i = 0; i < HAZ_DEPTH; i++) stg_rd[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
        stg_rd_we   = HAZ_DEPTH'($urandom);
        if (dec_valid) begin
            c = $urandom_range(0, 11);
            case (c)
                0: dec_is_jump = 1'b1;
                1: dec_is_branch = 1'b1;
                2: dec_is_load = 1'b1;
                3, 4: dec_is_store = 1'b1;
                5: begin dec_is_jump = 1'b1; dec_is_load = 1'b1; dec_is_store = 1'b1; end
                6: begin dec_is_branch = 1'b1; dec_is_store = 1'b1; end
                7: begin dec_is_load = 1'b1; dec_is_store = 1'b1; end
                default: ;
            endcase
        end
        br_taken = 1'($urandom_range(0, 1));
        mem_busy = ($urandom_range(0, 2) == 0);
    endtask

    initial begin
        int s0;
        rst = 1'b0;
        br_taken = 1'b0;
        mem_busy = 1'b0;
        clear_decode();
        model_reset();

        // Reset and release
        @(negedge clk);
        settle();
        chk("reset_state_lit", 32'(state), 32'd0);
        chk("reset_stall_lit", 32'(stall_cycles), 32'd0);
        advance();
        rst = 1'b1;
        settle();
        advance();
        settle();
        chk("run_after_release_lit", 32'(state), 32'd1);
        advance();

        // RAW on stage 0, then cleared
        dec_valid = 1'b1; dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
        stg_rd = {5'd0, 5'd5}; stg_rd_we = 2'b01;
        settle();
        chk("raw_bubble_lit", 32'(bubble), 32'd1);
        chk("raw_fetch_lit", 32'(en_fetch), 32'd0);
        advance();
        stg_rd_we = 2'b00;
        settle();
        chk("raw_cleared_fetch_lit", 32'(en_fetch), 32'd1);
        advance();

        // RAW via stage 1 on rs2
        clear_decode();
        dec_valid = 1'b1; dec_rs2 = 5'd7; dec_use_rs2 = 1'b1;
        stg_rd = {5'd7, 5'd3}; stg_rd_we = 2'b10;
        settle();
        chk("raw_stage1_bubble_lit", 32'(bubble), 32'd1);
        advance();

        // Register 0 never hazards
        clear_decode();
        dec_valid = 1'b1; dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; stg_rd_we = 2'b11;
        settle();
        chk("reg0_bubble_lit", 32'(bubble), 32'd0);
        chk("reg0_fetch_lit", 32'(en_fetch), 32'd1);
        advance();

        // Jump: two flush cycles
        clear_decode();
        dec_valid = 1'b1; dec_is_jump = 1'b1;
        settle();
        s0 = m_stall;
        advance();
        clear_decode();
        settle(); chk("jump_flush1_lit", 32'(flush), 32'd1); advance();
        settle(); chk("jump_flush2_lit", 32'(flush), 32'd1); advance();
        settle();
        chk("jump_done_state_lit", 32'(state), 32'd1);
        chk("jump_done_flush_lit", 32'(flush), 32'd0);
        chk("jump_stall_delta_lit", 32'(stall_cycles), 32'(s0 + 2));
        advance();

        // Taken branch
        dec_valid = 1'b1; dec_is_branch = 1'b1;
        settle(); advance();
        clear_decode(); br_taken = 1'b1;
        settle();
        chk("br_wait_state_lit", 32'(state), 32'd3);
        chk("br_wait_fetch_lit", 32'(en_fetch), 32'd0);
        advance();
        br_taken = 1'b0;
        settle(); chk("br_flush1_lit", 32'(flush), 32'd1); advance();
        settle(); chk("br_flush2_lit", 32'(flush), 32'd1); advance();
        settle(); chk("br_done_state_lit", 32'(state), 32'd1); advance();

        // Not-taken branch
        dec_valid = 1'b1; dec_is_branch = 1'b1;
        settle(); advance();
        clear_decode(); br_taken = 1'b0;
        settle();
        chk("brnt_wait_state_lit", 32'(state), 32'd3);
        chk("brnt_wait_flush_lit", 32'(flush), 32'd0);
        advance();
        settle();
        chk("brnt_run_state_lit", 32'(state), 32'd1);
        chk("brnt_run_flush_lit", 32'(flush), 32'd0);
        advance();

        // Posted store, then second store while memory busy
        mem_busy = 1'b1;
        dec_valid = 1'b1; dec_is_store = 1'b1;
        settle(); chk("st1_fetch_lit", 32'(en_fetch), 32'd1); advance();
        settle();
        chk("st1_pending_lit", 32'(wr_pending), 32'd1);
        chk("st2_accept_fetch_lit", 32'(en_fetch), 32'd1);
        advance();
        clear_decode();
        for (int k = 0; k < 4; k++) begin
            settle(); chk("st2_memwait_lit", 32'(state), 32'd4); advance();
        end
        mem_busy = 1'b0;
        settle(); chk("st2_memwait_last_lit", 32'(state), 32'd4); advance();
        settle();
        chk("st2_done_state_lit", 32'(state), 32'd1);
        chk("st2_done_pending_lit", 32'(wr_pending), 32'd0);
        advance();

        // Load held by mem_busy, async reset mid-wait
        mem_busy = 1'b1;
        dec_valid = 1'b1; dec_is_load = 1'b1;
        settle(); advance();
        clear_decode();
        for (int k = 0; k < 4; k++) begin settle(); advance(); end
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs_lit",
            32'({en_fetch, en_decode, en_exec, en_wb, en_regs, en_addr, bubble, flush}), 32'd0);
        chk("async_rst_state_lit", 32'(state), 32'd0);
        chk("async_rst_stall_lit", 32'(stall_cycles), 32'd0);
        chk("async_rst_pending_lit", 32'(wr_pending), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        settle(); advance();
        settle(); chk("run_after_rst_lit", 32'(state), 32'd1); advance();
        mem_busy = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rand_inputs();
            settle();
            advance();
        end

        // Drive stall counter to saturation with a long memory wait
        clear_decode();
        br_taken = 1'b0;
        mem_busy = 1'b0;
        for (int k = 0; k < 40 && mode() != M_RUN; k++) begin settle(); advance(); end
        chk("sat_setup_run_lit", 32'(state), 32'd1);
        dec_valid = 1'b1; dec_is_load = 1'b1; mem_busy = 1'b1;
        settle(); advance();
        clear_decode();
        for (int k = 0; k < 65600; k++) begin settle(); advance(); end
        chk("stall_saturated_lit", 32'(stall_cycles), 32'h0000_FFFF);
        mem_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin settle(); advance(); end
        settle();
        chk("stall_no_wrap_lit", 32'(stall_cycles), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
